// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage and the decoder it feeds.
package fetch_pkg;

    // Fetch stage control states.
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_TRAP  = 2'd3
    } fetch_state_e;

    // Instruction word presented while nothing has been fetched yet.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Primary opcodes (instr[31:26]) shared with the decoder.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LI    = 6'b100111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Sign-extend a 16-bit immediate to a full word.
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: jump target, taken branch target, or sequential pc+4.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        zero,
    input  logic [15:0] Const,     // decoder immediate; "const" is a reserved word
    input  logic [25:0] address,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] imm_sext;
    logic [31:0] br_off;

    // Jump beats branch; a branch is taken only when the ALU reports zero.
    always_comb begin
        // NOTE: every output of an always_comb gets a value on every path, so no latch is inferred.
        pc4      = pc + 32'd4;
        imm_sext = sext16(Const);
        br_off   = {imm_sext[29:0], 2'b00};
        if (Jump) begin
            next_pc = {pc4[31:28], address, 2'b00};
        end else if (Branch && zero) begin
            next_pc = pc4 + br_off;
        end else begin
            next_pc = pc4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack handshake, instruction
// register for the decoder, and a sticky trap on bus error.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] InstrReg,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        Jump,
    input  logic        Branch,
    input  logic [15:0] Const,
    input  logic [25:0] address,
    input  logic        zero,
    input  logic        exec_stall,
    output logic        trap
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         trap_q, trap_d;
    logic [31:0]  next_pc;

    fetch_next_pc u_next_pc (
        .pc      (pc_q),
        .Jump    (Jump),
        .Branch  (Branch),
        .zero    (zero),
        .Const   (Const),
        .address (address),
        .next_pc (next_pc)
    );

    // Next-state logic; decoder inputs only matter when leaving EXEC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    if (imem_err) begin
                        state_d = ST_TRAP;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (!exec_stall) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_RESET;
        endcase
        valid_d = (state_d == ST_EXEC);
        trap_d  = (state_d == ST_TRAP);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            state_q <= ST_RESET;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            trap_q  <= trap_d;
        end
    end

    // Request is decoded from state only, never from the ack.
    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign InstrReg    = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign trap        = trap_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps plus randomized
// instruction streams checked against a behavioural next-PC model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] InstrReg;
    logic        instr_valid;
    logic [31:0] pc;
    logic        Jump;
    logic        Branch;
    logic [15:0] Const;
    logic [25:0] address;
    logic        zero;
    logic        exec_stall;
    logic        trap;

    int n_checks = 0;
    int n_errs   = 0;

    // Model state: address and word of the instruction currently held.
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .InstrReg    (InstrReg),
        .instr_valid (instr_valid),
        .pc          (pc),
        .Jump        (Jump),
        .Branch      (Branch),
        .Const       (Const),
        .address     (address),
        .zero        (zero),
        .exec_stall  (exec_stall),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference next PC, computed as plain integer arithmetic modulo 2^32.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input bit j, input bit b,
                                             input bit z, input logic [15:0] c,
                                             input logic [25:0] a);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        if (j) return (seq & 32'hF000_0000) | (32'(a) * 32'd4);
        if (b && z) begin
            off = int'($signed(c));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic scramble_decoder();
        Jump    = 1'($urandom);
        Branch  = 1'($urandom);
        zero    = 1'($urandom);
        Const   = 16'($urandom);
        address = 26'($urandom);
    endtask

    // Entered with the DUT in FETCH; waits `dly` cycles then acks with `word`.
    task automatic fetch(input int dly, input logic [31:0] word, input bit err);
        scramble_decoder();
        exec_stall = 1'($urandom);
        for (int i = 0; i < dly; i++) begin
            imem_ack = 1'b0;
            check("fetch_wait_req", 32'(imem_req), 32'd1);
            check("fetch_wait_addr", imem_addr, m_pc);
            tick();
        end
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        imem_ack   = 1'b1;
        imem_rdata = word;
        imem_err   = err;
        tick();
        imem_ack   = 1'b0;
        imem_err   = 1'b0;
        imem_rdata = $urandom;
        if (!err) begin
            m_instr = word;
            check("exec_valid", 32'(instr_valid), 32'd1);
            check("exec_instr", InstrReg, m_instr);
            check("exec_pc", pc, m_pc);
            check("exec_req", 32'(imem_req), 32'd0);
        end else begin
            check("err_trap", 32'(trap), 32'd1);
            check("err_req", 32'(imem_req), 32'd0);
            check("err_valid", 32'(instr_valid), 32'd0);
            check("err_instr", InstrReg, m_instr);
        end
    endtask

    // Entered with the DUT in EXEC; holds for `stall` cycles then advances.
    task automatic exec(input bit j, input bit b, input bit z, input logic [15:0] c,
                        input logic [25:0] a, input int stall);
        Jump = j; Branch = b; zero = z; Const = c; address = a;
        for (int i = 0; i < stall; i++) begin
            exec_stall = 1'b1;
            tick();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", pc, m_pc);
            check("stall_instr", InstrReg, m_instr);
        end
        exec_stall = 1'b0;
        tick();
        m_pc = ref_next(m_pc, j, b, z, c, a);
        check("next_pc", pc, m_pc);
        check("next_valid", 32'(instr_valid), 32'd0);
        check("next_req", 32'(imem_req), 32'd1);
        check("next_addr", imem_addr, m_pc);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        imem_ack = 1'b0;
        tick();
        check("rst_pc", pc, RST_PC);
        check("rst_instr", InstrReg, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        reset_n = 1'b1;
        check("rst_hold_req", 32'(imem_req), 32'd0);
        tick();
        m_pc    = RST_PC;
        m_instr = 32'h0;
        check("rst_fetch_req", 32'(imem_req), 32'd1);
        check("rst_fetch_addr", imem_addr, RST_PC);
    endtask

    initial begin
        reset_n    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        imem_err   = 1'b0;
        exec_stall = 1'b0;
        Jump = 1'b0; Branch = 1'b0; zero = 1'b0; Const = 16'h0; address = 26'h0;
        m_pc = RST_PC;
        m_instr = 32'h0;
        tick();

        // Reset values and first fetch address.
        do_reset();

        // Sequential fetch from RESET_PC up to 0x00400010.
        for (int i = 0; i < 4; i++) begin
            fetch(0, $urandom, 1'b0);
            exec(1'b0, 1'b0, 1'($urandom), 16'($urandom), 26'($urandom), 0);
            if (i == 1) check("seq_pc_0x08", pc, 32'h0040_0008);
        end
        check("seq_pc_0x10", pc, 32'h0040_0010);

        // Taken backward branch from 0x00400010.
        fetch(0, $urandom, 1'b0);
        exec(1'b0, 1'b1, 1'b1, 16'hFFFC, 26'h0, 0);
        check("br_taken", pc, 32'h0040_0004);

        // Jump back to 0x00400010, then untaken branch.
        fetch(0, $urandom, 1'b0);
        exec(1'b1, 1'b0, 1'b0, 16'h0, 26'h010_0004, 0);
        check("jump_0x10", pc, 32'h0040_0010);
        fetch(0, $urandom, 1'b0);
        exec(1'b0, 1'b1, 1'b0, 16'hFFFC, 26'h0, 0);
        check("br_not_taken", pc, 32'h0040_0014);

        // Jump and branch together: jump wins.
        fetch(0, $urandom, 1'b0);
        exec(1'b1, 1'b0, 1'b0, 16'h0, 26'h010_0004, 0);
        fetch(0, $urandom, 1'b0);
        exec(1'b1, 1'b1, 1'b1, 16'hFFFC, 26'h010_0040, 0);
        check("jump_wins", pc, 32'h0040_0100);

        // Slow memory (3 wait cycles) and a 2-cycle execution stall.
        fetch(3, $urandom, 1'b0);
        exec(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 2);

        // Reach 0xFFFFFFFC via jump to 0 and a backward branch, then wrap.
        fetch(0, $urandom, 1'b0);
        exec(1'b1, 1'b0, 1'b0, 16'h0, 26'h0, 0);
        check("jump_zero", pc, 32'h0000_0000);
        fetch(0, $urandom, 1'b0);
        exec(1'b0, 1'b1, 1'b1, 16'hFFFE, 26'h0, 0);
        check("br_to_top", pc, 32'hFFFF_FFFC);
        fetch(1, $urandom, 1'b0);
        exec(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0);
        check("wrap_pc", pc, 32'h0000_0000);
        check("wrap_no_trap", 32'(trap), 32'd0);

        // Randomized instruction stream.
        for (int i = 0; i < 24; i++) begin
            fetch(int'($urandom_range(0, 2)), $urandom, 1'b0);
            exec(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 16'($urandom),
                 26'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset asserted mid-FETCH; an ack during RESET is ignored.
        reset_n  = 1'b0;
        imem_ack = 1'b0;
        tick();
        check("midrst_req", 32'(imem_req), 32'd0);
        reset_n    = 1'b1;
        imem_ack   = 1'b1;
        imem_err   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        imem_err = 1'b0;
        m_pc     = RST_PC;
        m_instr  = 32'h0;
        check("midrst_instr", InstrReg, 32'h0);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_trap", 32'(trap), 32'd0);
        check("midrst_req_again", 32'(imem_req), 32'd1);
        check("midrst_addr", imem_addr, RST_PC);
        fetch(0, $urandom, 1'b0);
        exec(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0);

        // Bus error traps; trap is sticky while acks keep arriving.
        fetch(1, $urandom, 1'b1);
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'b1;
            imem_err   = 1'($urandom);
            imem_rdata = $urandom;
            scramble_decoder();
            tick();
            check("trap_sticky", 32'(trap), 32'd1);
            check("trap_req", 32'(imem_req), 32'd0);
            check("trap_valid", 32'(instr_valid), 32'd0);
            check("trap_instr", InstrReg, m_instr);
        end
        imem_ack = 1'b0;
        imem_err = 1'b0;

        // One-cycle reset clears the trap and restarts at RESET_PC.
        do_reset();
        fetch(0, $urandom, 1'b0);
        exec(1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 0);
        check("post_trap_pc", pc, 32'h0040_0004);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
